man_tx_ctrl: RTL and testbench
==============================

// Module: man_tx_ctrl
// PURPOSE
//   Frame sequencer for the Manchester encoder. Accepts a tag response as a byte
//   stream (valid/ready), then serialises: header of 1s, data MSB-first with
//   optional even parity per byte, stop bit 0, then an idle gap. Drives the
//   encoder's bit clock, enable and data lines from one system clock.
// PARAMETERS
//   HALF_DIV   16  system clocks per half bit period (>=2); bit = 2*HALF_DIV clks
//   HDR_BITS    9  header length in bits, all '1'
//   PARITY_EN   1  1: append even parity bit after each byte; 0: none
//   GAP_BITS    4  bit periods with encoder disabled after stop bit / abort
// PORTS
//   clk           in   1  system clock, all logic on posedge
//   rst           in   1  synchronous reset, active-high
//   in_start      in   1  1-cycle pulse; starts a frame (ignored unless IDLE)
//   in_byte       in   8  payload byte
//   in_valid      in   1  in_byte/in_last valid
//   in_last       in   1  in_byte is the final byte of the frame
//   out_ready     out  1  holding register empty; byte accepted on valid&&ready
//   out_bit_clk   out  1  encoder bit clock
//   out_enc_en    out  1  encoder enable
//   out_enc_data  out  1  encoder data bit
//   out_busy      out  1  state != IDLE
//   out_err       out  1  1-cycle pulse on payload underrun abort
// BEHAVIOUR
//   Reset (rst=1 at posedge, any state): all outputs 0, state IDLE, holding reg
//     empty, phase/bit counters 0. Reset mid-frame aborts with no out_err.
//   Bit timing: phase counter 0..2*HALF_DIV-1 per bit. out_enc_data updates at
//     phase 0; out_bit_clk=1 for phases 1..HALF_DIV, else 0 (data leads rising
//     edge by one clk). out_enc_en=1 in HEADER/DATA/PARITY/STOP, 0 otherwise.
//   States: IDLE -> HEADER -> DATA <-> PARITY -> STOP -> GAP -> IDLE.
//     IDLE: in_start=1 -> HEADER, phase 0 on next clk. out_ready=0.
//     HEADER: HDR_BITS bits of 1. Latency in_start -> first out_bit_clk rise =
//       2 clks.
//     DATA: 8 bits from shift reg, MSB first. At the last phase of the last
//       header bit / last bit of previous byte (or parity bit), the holding reg
//       is moved to the shift reg. Parity = XOR of the 8 bits (even).
//     PARITY (PARITY_EN=1 only): one bit; else DATA goes straight to next byte.
//     After the byte tagged in_last (and its parity) -> STOP: one bit of 0.
//     GAP: GAP_BITS bit periods, en=0, data=0, bit_clk=0; then IDLE.
//   Handshake: out_ready=1 while holding reg empty and state in
//     HEADER/DATA/PARITY and last byte not yet accepted. Byte may be accepted
//     at any phase; in_valid in IDLE/STOP/GAP is not consumed. Hold-to-shift
//     transfer and a new acceptance in the same clk: holding reg takes new byte.
//   Underrun: at a hold-to-shift point with holding reg empty -> out_err=1 for
//     1 clk, en=0 from next clk, go to GAP (full GAP_BITS), then IDLE.
//   in_start while busy is ignored. in_last with in_valid=0 is ignored.
//   Counters: phase ceil(log2(2*HALF_DIV)) bits, bit count wraps per field;
//     no overflow beyond field lengths.
// TESTING
//   1 HALF_DIV=4,HDR=9,PAR=1: start, bytes 0xA5,0x3C(last) preloaded ->
//     en high 9+9+9+1=28 bits (224 clks), data 1x9,10100101,0,00111100,0,0.
//   2 PARITY_EN=0, one byte 0xFF last -> 9 ones, 8 ones, stop 0; 18 bits then
//     GAP 4 bits, out_busy falls 18*8+4*8=176 clks after first bit.
//   3 Start with no bytes supplied -> out_err pulse at end of header (phase 7
//     of bit 9), en=0 next clk, IDLE after 4 gap bits.
//   4 rst pulsed mid-DATA -> next clk all outputs 0, out_err=0; new start OK.
//   5 in_start asserted during DATA and GAP -> no effect on frame or timing.
//   6 Backpressure: in_valid held with 3 bytes; out_ready high at most one
//     accept per byte slot; bit_clk period exactly 8 clks throughout.

Source files
------------

// File: rtl/man_tx_ctrl.sv
// Manchester encoder frame sequencer: accepts payload bytes over valid/ready,
// then emits header 1s, MSB-first data with optional even parity, a stop 0
// and an idle gap, driving the encoder bit clock / enable / data lines.
module man_tx_ctrl #(
    parameter int HALF_DIV  = 16,
    parameter int HDR_BITS  = 9,
    parameter int PARITY_EN = 1,
    parameter int GAP_BITS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_start,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       out_ready,
    output logic       out_bit_clk,
    output logic       out_enc_en,
    output logic       out_enc_data,
    output logic       out_busy,
    output logic       out_err
);

    localparam int PER  = 2 * HALF_DIV;
    localparam int PW   = $clog2(PER);
    localparam int MAXB = (HDR_BITS > 8) ? ((HDR_BITS > GAP_BITS) ? HDR_BITS : GAP_BITS)
                                         : ((GAP_BITS > 8) ? GAP_BITS : 8);
    localparam int BW   = $clog2(MAXB);

    localparam logic [PW-1:0] PH_LAST  = PW'(PER - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(HALF_DIV);
    localparam logic [BW-1:0] HDR_LAST = BW'(HDR_BITS - 1);
    localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BITS - 1);
    localparam logic [BW-1:0] DAT_LAST = BW'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          cur_last_q, cur_last_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_vld_q, hold_vld_d;
    logic          last_acc_q, last_acc_d;

    logic enable, ready, accept, end_bit, xfer, err;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            cur_last_q  <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            last_acc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            cur_last_q  <= cur_last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_vld_q  <= hold_vld_d;
            last_acc_q  <= last_acc_d;
        end
    end

    // Next-state, handshake and bit sequencing
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        cur_last_d  = cur_last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_vld_d  = hold_vld_q;
        last_acc_d  = last_acc_q;
        xfer        = 1'b0;
        err         = 1'b0;

        enable  = (state_q == S_HEADER) || (state_q == S_DATA) ||
                  (state_q == S_PARITY) || (state_q == S_STOP);
        ready   = !hold_vld_q && !last_acc_q &&
                  ((state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_PARITY));
        accept  = in_valid && ready;
        end_bit = (phase_q == PH_LAST);

        if (accept) begin
            hold_d      = in_byte;
            hold_last_d = in_last;
            hold_vld_d  = 1'b1;
            if (in_last) last_acc_d = 1'b1;
        end

        if (state_q == S_IDLE) begin
            phase_d = '0;
        end else begin
            phase_d = end_bit ? '0 : phase_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                bit_d      = '0;
                last_acc_d = 1'b0;
                if (in_start) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (end_bit) begin
                    if (bit_q == HDR_LAST) xfer = 1'b1;
                    else                   bit_d = bit_q + 1'b1;
                end
            end
            S_DATA: begin
                if (end_bit) begin
                    shift_d = shift_q << 1;
                    if (bit_q == DAT_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) state_d = S_PARITY;
                        else if (cur_last_q) state_d = S_STOP;
                        else                 xfer = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (end_bit) begin
                    if (cur_last_q) state_d = S_STOP;
                    else            xfer = 1'b1;
                end
            end
            S_STOP: begin
                if (end_bit) begin
                    state_d = S_GAP;
                    bit_d   = '0;
                end
            end
            S_GAP: begin
                if (end_bit) begin
                    if (bit_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving exactly at an empty-hold transfer point bypasses the
        // holding register straight into the shifter rather than underrunning.
        if (xfer) begin
            bit_d = '0;
            if (hold_vld_q) begin
                shift_d    = hold_q;
                par_d      = ^hold_q;
                cur_last_d = hold_last_q;
                hold_vld_d = accept;
                state_d    = S_DATA;
            end else if (accept) begin
                shift_d    = in_byte;
                par_d      = ^in_byte;
                cur_last_d = in_last;
                hold_vld_d = 1'b0;
                state_d    = S_DATA;
            end else begin
                err     = 1'b1;
                state_d = S_GAP;
            end
        end
    end

    // Encoder-facing outputs decoded from state and bit phase
    always_comb begin
        out_ready    = ready;
        out_enc_en   = enable;
        out_bit_clk  = enable && (phase_q != '0) && (phase_q <= PH_HALF);
        out_busy     = (state_q != S_IDLE);
        out_err      = err;
        out_enc_data = 1'b0;
        unique case (state_q)
            S_HEADER: out_enc_data = 1'b1;
            S_DATA:   out_enc_data = shift_q[7];
            S_PARITY: out_enc_data = par_q;
            default:  out_enc_data = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_man_tx_ctrl.sv
// Randomized bench for man_tx_ctrl: two instances (parity on / off) share the
// stimulus via a select; expected waveforms come from a per-frame bit list.
module tb_man_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last  = 1'b0;
    logic [7:0] in_byte  = 8'h00;
    logic       sel      = 1'b0;

    logic a_start, a_valid, b_start, b_valid;
    assign a_start = in_start & ~sel;
    assign a_valid = in_valid & ~sel;
    assign b_start = in_start & sel;
    assign b_valid = in_valid & sel;

    logic a_ready, a_bclk, a_en, a_data, a_busy, a_err;
    logic b_ready, b_bclk, b_en, b_data, b_busy, b_err;
    logic w_ready, w_bclk, w_en, w_data, w_busy, w_err;
    assign w_ready = sel ? b_ready : a_ready;
    assign w_bclk  = sel ? b_bclk  : a_bclk;
    assign w_en    = sel ? b_en    : a_en;
    assign w_data  = sel ? b_data  : a_data;
    assign w_busy  = sel ? b_busy  : a_busy;
    assign w_err   = sel ? b_err   : a_err;

    man_tx_ctrl #(.HALF_DIV(4), .HDR_BITS(9), .PARITY_EN(1), .GAP_BITS(4)) u_a (
        .clk(clk), .rst(rst), .in_start(a_start), .in_byte(in_byte),
        .in_valid(a_valid), .in_last(in_last), .out_ready(a_ready),
        .out_bit_clk(a_bclk), .out_enc_en(a_en), .out_enc_data(a_data),
        .out_busy(a_busy), .out_err(a_err));

    man_tx_ctrl #(.HALF_DIV(4), .HDR_BITS(9), .PARITY_EN(0), .GAP_BITS(4)) u_b (
        .clk(clk), .rst(rst), .in_start(b_start), .in_byte(in_byte),
        .in_valid(b_valid), .in_last(in_last), .out_ready(b_ready),
        .out_bit_clk(b_bclk), .out_enc_en(b_en), .out_enc_data(b_data),
        .out_busy(b_busy), .out_err(b_err));

    int n_total = 0;
    int n_bad   = 0;
    int acc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] fbytes[4];
    int         fn;
    bit         exp_bits[$];

    // Frame content from the rules: header ones, bytes MSB first (+even parity), stop 0
    task automatic build_bits(input bit par);
        exp_bits.delete();
        repeat (9) exp_bits.push_back(1'b1);
        for (int i = 0; i < fn; i++) begin
            for (int k = 7; k >= 0; k--) exp_bits.push_back(fbytes[i][k]);
            if (par) exp_bits.push_back(^fbytes[i]);
        end
        exp_bits.push_back(1'b0);
    endtask

    task automatic feeder(input bit burst);
        int waited;
        for (int i = 0; i < fn; i++) begin
            if (!burst) repeat ($urandom_range(20, 0)) @(negedge clk);
            in_valid = 1'b1;
            in_byte  = fbytes[i];
            in_last  = (i == fn - 1);
            waited   = 0;
            while (!w_ready && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            if (!w_ready) begin
                chk("feed_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            if (!burst) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Per-cycle comparison against the bit list; c=0 is phase 0 of the first header bit
    task automatic check_frame();
        int nb, total, b, ph;
        bit prev_acc;
        nb       = exp_bits.size();
        total    = (nb + 4) * 8;
        acc_cnt  = 0;
        prev_acc = 1'b0;
        for (int c = 0; c <= total; c++) begin
            #1;
            b  = c / 8;
            ph = c % 8;
            chk("en",   w_en,   b < nb);
            chk("data", w_data, (b < nb) ? exp_bits[b] : 1'b0);
            chk("bclk", w_bclk, (b < nb) && ph >= 1 && ph <= 4);
            chk("busy", w_busy, c < total);
            chk("err",  w_err,  1'b0);
            if (prev_acc) chk("ready_after_acc", w_ready, 1'b0);
            prev_acc = in_valid && w_ready;
            if (prev_acc) acc_cnt++;
            in_start = (c < total) && ($urandom_range(15, 0) == 0);
            if (c < total) @(negedge clk);
        end
        in_start = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic run_frame(input bit s, input int n, input bit burst, input bit rnd);
        sel = s;
        fn  = n;
        if (rnd) for (int i = 0; i < n; i++) fbytes[i] = 8'($urandom_range(255, 0));
        build_bits(!s);
        start_pulse();
        fork
            feeder(burst);
            check_frame();
        join
        chk("accepts", acc_cnt, n);
    endtask

    initial begin
        int b, ph;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_en",    a_en,    1'b0);
        chk("rst_bclk",  a_bclk,  1'b0);
        chk("rst_data",  a_data,  1'b0);
        chk("rst_busy",  a_busy,  1'b0);
        chk("rst_err",   a_err,   1'b0);
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_busy_b", b_busy, 1'b0);
        rst = 1'b0;

        // Two-byte frame with parity
        fbytes[0] = 8'hA5;
        fbytes[1] = 8'h3C;
        run_frame(1'b0, 2, 1'b0, 1'b0);

        // Single 0xFF frame, parity off
        fbytes[0] = 8'hFF;
        run_frame(1'b1, 1, 1'b0, 1'b0);

        // Underrun: no payload supplied
        sel = 1'b0;
        start_pulse();
        for (int c = 0; c <= 104; c++) begin
            #1;
            b  = c / 8;
            ph = c % 8;
            chk("ur_err",  w_err,  c == 71);
            chk("ur_en",   w_en,   c < 72);
            chk("ur_data", w_data, c < 72);
            chk("ur_bclk", w_bclk, c < 72 && ph >= 1 && ph <= 4);
            chk("ur_busy", w_busy, c < 104);
            if (c == 10) chk("ur_ready", w_ready, 1'b1);
            if (c < 104) @(negedge clk);
        end

        // Reset mid-DATA, then a fresh frame
        sel      = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'h5A;
        in_last  = 1'b1;
        start_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (98) @(negedge clk);
        #1;
        chk("pre_rst_en", w_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_en",    w_en,    1'b0);
        chk("mrst_bclk",  w_bclk,  1'b0);
        chk("mrst_data",  w_data,  1'b0);
        chk("mrst_busy",  w_busy,  1'b0);
        chk("mrst_err",   w_err,   1'b0);
        chk("mrst_ready", w_ready, 1'b0);
        rst = 1'b0;
        run_frame(1'b0, 1, 1'b0, 1'b1);

        // Backpressure: three bytes with valid held continuously
        run_frame(1'b0, 3, 1'b1, 1'b1);

        // Randomized frames across both instances
        for (int f = 0; f < 10; f++)
            run_frame(1'($urandom_range(1, 0)), $urandom_range(4, 1),
                      1'($urandom_range(1, 0)), 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
